stage_sequencer: RTL and testbench

- Synchronous controller that sequences the non-pipelined LEGv8 datapath through its five stages: Fetch, Decode-read, Execute, Memory and Writeback.
- Replaces the fixed phase-delayed clock taps with one-hot stage enables on a single clock.
- Adds a memory request/acknowledge handshake with timeout, halt control and retirement counting.
- Sits beside the Fetch/Decode/Execute/Memory/Writeback instances and drives their enables.

---
 rtl/stage_sequencer.sv | 125 ++++++++++++
 tb/tb_stage_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Five-stage sequencer for the non-pipelined LEGv8 datapath: one-hot stage enables,
// memory handshake with timeout, halt control and retirement/cycle counters.
module stage_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned MAX_INSTR   = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             reg_write,
   input  logic             halt_req,
   input  logic             mem_ack,
   output logic             pc_reset,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             execute_en,
   output logic             mem_en,
   output logic             mem_req,
   output logic             wb_en,
   output logic             pc_update,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired,
   output logic [CNT_W-1:0] cycles
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_EXECUTE   = 4'd3;
   localparam logic [3:0] S_MEMORY    = 4'd4;
   localparam logic [3:0] S_MEM_WAIT  = 4'd5;
   localparam logic [3:0] S_WRITEBACK = 4'd6;
   localparam logic [3:0] S_HALT      = 4'd7;
   localparam logic [3:0] S_FAULT     = 4'd8;

   localparam logic [7:0]       TMO_LIMIT     = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] RETIRE_LIMIT  = CNT_W'(MAX_INSTR);
   localparam bit               HALT_ON_COUNT = (MAX_INSTR != 0);

   logic [3:0]       state;
   logic [3:0]       state_next;
   logic [7:0]       tmo_cnt;
   logic [7:0]       tmo_inc;
   logic [7:0]       tmo_next;
   logic             mem_access;
   logic [CNT_W-1:0] retired_inc;

   assign mem_access  = mem_read | mem_write;
   assign tmo_inc     = tmo_cnt + 8'd1;
   assign retired_inc = retired + CNT_W'(1);

   always_comb begin
      state_next = state;
      tmo_next   = '0;
      case (state)
         S_IDLE:      if (run) state_next = S_FETCH;
         S_FETCH:     state_next = S_DECODE;
         S_DECODE:    state_next = S_EXECUTE;
         S_EXECUTE:   state_next = S_MEMORY;
         S_MEMORY: begin
            if (mem_access && !mem_ack) state_next = S_MEM_WAIT;
            else                        state_next = S_WRITEBACK;
         end
         S_MEM_WAIT: begin
            // ack is checked first so a same-cycle ack beats the timeout
            if (mem_ack) begin
               state_next = S_WRITEBACK;
            end else begin
               tmo_next = tmo_inc;
               if (tmo_inc == TMO_LIMIT) state_next = S_FAULT;
            end
         end
         S_WRITEBACK: begin
            if (halt_req)                                        state_next = S_HALT;
            else if (HALT_ON_COUNT && retired_inc == RETIRE_LIMIT) state_next = S_HALT;
            else if (run)                                        state_next = S_FETCH;
            else                                                 state_next = S_IDLE;
         end
         S_HALT:      state_next = S_HALT;
         S_FAULT:     state_next = S_FAULT;
         default:     state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from state_next so each flop holds the value for the state being entered.
   // mem_req/wb_en use controls seen on the entry edge; they are stable from DECODE onward.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         tmo_cnt    <= '0;
         pc_reset   <= 1'b1;
         fetch_en   <= 1'b0;
         decode_en  <= 1'b0;
         execute_en <= 1'b0;
         mem_en     <= 1'b0;
         mem_req    <= 1'b0;
         wb_en      <= 1'b0;
         pc_update  <= 1'b0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         retired    <= '0;
         cycles     <= '0;
      end else begin
         state      <= state_next;
         tmo_cnt    <= tmo_next;
         pc_reset   <= 1'b0;
         fetch_en   <= (state_next == S_FETCH);
         decode_en  <= (state_next == S_DECODE);
         execute_en <= (state_next == S_EXECUTE);
         mem_en     <= (state_next == S_MEMORY) || (state_next == S_MEM_WAIT);
         mem_req    <= (state_next == S_MEM_WAIT) || ((state_next == S_MEMORY) && mem_access);
         wb_en      <= (state_next == S_WRITEBACK) && reg_write;
         pc_update  <= (state_next == S_WRITEBACK);
         halted     <= (state_next == S_HALT) || (state_next == S_FAULT);
         fault      <= (state_next == S_FAULT);
         if (state == S_WRITEBACK) retired <= retired_inc;
         if (state != S_HALT && state != S_FAULT) cycles <= cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: vector table, per-instruction expected-trace model with
// random stimulus, and directed halt / timeout / reset-abort / instruction-limit sequences.
module tb_stage_sequencer;

   localparam int unsigned TMO = 15;

   // output vector bits: pc_reset fetch decode execute mem_en mem_req wb_en pc_update halted fault
   localparam logic [9:0] V_IDLE_PCR = 10'h200;
   localparam logic [9:0] V_IDLE     = 10'h000;
   localparam logic [9:0] V_F        = 10'h100;
   localparam logic [9:0] V_D        = 10'h080;
   localparam logic [9:0] V_E        = 10'h040;
   localparam logic [9:0] V_M        = 10'h020;
   localparam logic [9:0] V_MR       = 10'h030;
   localparam logic [9:0] V_W        = 10'h030;
   localparam logic [9:0] V_WB       = 10'h004;
   localparam logic [9:0] V_WBW      = 10'h00C;
   localparam logic [9:0] V_HALT     = 10'h002;
   localparam logic [9:0] V_FAULT    = 10'h003;

   logic clk;
   logic reset, run, mem_read, mem_write, reg_write, halt_req, mem_ack;
   logic pc_reset, fetch_en, decode_en, execute_en, mem_en, mem_req, wb_en, pc_update, halted, fault;
   logic [31:0] retired, cycles;
   logic [9:0]  outv;

   logic reset1, run1, zero;
   logic pc_reset1, fetch_en1, decode_en1, execute_en1, mem_en1, mem_req1, wb_en1, pc_update1, halted1, fault1;
   logic [31:0] retired1, cycles1;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_ret, m_cyc;
   bit m_in_wb, m_stop;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign outv = {pc_reset, fetch_en, decode_en, execute_en, mem_en, mem_req, wb_en, pc_update, halted, fault};

   stage_sequencer #(.MEM_TIMEOUT(TMO), .MAX_INSTR(0), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .halt_req(halt_req), .mem_ack(mem_ack), .pc_reset(pc_reset),
      .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en), .mem_en(mem_en),
      .mem_req(mem_req), .wb_en(wb_en), .pc_update(pc_update), .halted(halted), .fault(fault),
      .retired(retired), .cycles(cycles)
   );

   stage_sequencer #(.MEM_TIMEOUT(TMO), .MAX_INSTR(20), .CNT_W(32)) dut_lim (
      .clk(clk), .reset(reset1), .run(run1), .mem_read(zero), .mem_write(zero),
      .reg_write(zero), .halt_req(zero), .mem_ack(zero), .pc_reset(pc_reset1),
      .fetch_en(fetch_en1), .decode_en(decode_en1), .execute_en(execute_en1), .mem_en(mem_en1),
      .mem_req(mem_req1), .wb_en(wb_en1), .pc_update(pc_update1), .halted(halted1), .fault(fault1),
      .retired(retired1), .cycles(cycles1)
   );

   typedef struct packed {
      logic [9:0]  exp;
      logic [31:0] ret;
      logic [31:0] cyc;
      logic run, rd, wr, rw, ack, hlt;
   } row_t;

   row_t tbl [22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // advance one clock and compare against the expected outputs for the new cycle
   task automatic tick(input logic [9:0] exp, input string name);
      @(posedge clk);
      if (!m_stop)  m_cyc = m_cyc + 32'd1;
      if (m_in_wb)  m_ret = m_ret + 32'd1;
      #1;
      m_in_wb = exp[2];
      m_stop  = exp[1];
      chk({name, " outputs"}, 32'(outv), 32'(exp));
      chk({name, " retired"}, retired, m_ret);
      chk({name, " cycles"}, cycles, m_cyc);
   endtask

   // called in an IDLE or WRITEBACK cycle with run=1; returns in the WRITEBACK (or FAULT) cycle
   task automatic instr(input bit rd, input bit wr, input bit rw, input int unsigned delay,
                        output bit faulted);
      faulted   = 1'b0;
      mem_read  = rd;
      mem_write = wr;
      reg_write = rw;
      mem_ack   = 1'b0;
      tick(V_F, "fetch");
      run = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      tick(V_D, "decode");
      halt_req = 1'($urandom_range(0, 1));
      tick(V_E, "execute");
      halt_req = 1'($urandom_range(0, 1));
      tick((rd | wr) ? V_MR : V_M, "memory");
      halt_req = 1'($urandom_range(0, 1));
      mem_ack = (rd | wr) ? (delay == 0) : 1'($urandom_range(0, 1));
      if ((rd | wr) && delay != 0) begin
         for (int unsigned k = 1; k <= delay; k++) begin
            tick(V_W, "mem_wait");
            halt_req = 1'($urandom_range(0, 1));
            mem_ack = (k == delay);
            if (k == TMO && k != delay) begin
               tick(V_FAULT, "timeout fault");
               faulted  = 1'b1;
               mem_ack  = 1'b0;
               halt_req = 1'b0;
               return;
            end
         end
      end
      tick(rw ? V_WBW : V_WB, "writeback");
      mem_ack  = 1'b0;
      halt_req = 1'b0;
   endtask

   // async reset asserted between edges, checked before the next edge, released after it
   task automatic do_reset();
      #1 reset = 1'b0;
      #1;
      m_ret = '0; m_cyc = '0; m_in_wb = 1'b0; m_stop = 1'b0;
      chk("reset outputs", 32'(outv), 32'(V_IDLE_PCR));
      chk("reset retired", retired, 32'd0);
      chk("reset cycles", cycles, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit f;
      int unsigned gap, mode, dly;
      int n_pu, n_f;
      bit prev_pu, halt_after_pu;

      reset = 1'b0; run = 1'b0; mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
      halt_req = 1'b0; mem_ack = 1'b0; reset1 = 1'b0; run1 = 1'b0; zero = 1'b0;

      tbl[0]  = '{V_IDLE_PCR, 32'd0, 32'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{V_F,    32'd0, 32'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{V_D,    32'd0, 32'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{V_E,    32'd0, 32'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{V_M,    32'd0, 32'd4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{V_WB,   32'd0, 32'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{V_F,    32'd1, 32'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{V_D,    32'd1, 32'd7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{V_E,    32'd1, 32'd8,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{V_MR,   32'd1, 32'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{V_W,    32'd1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{V_W,    32'd1, 32'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{V_W,    32'd1, 32'd12, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{V_WBW,  32'd1, 32'd13, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{V_IDLE, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{V_IDLE, 32'd2, 32'd15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{V_F,    32'd2, 32'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[17] = '{V_D,    32'd2, 32'd17, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[18] = '{V_E,    32'd2, 32'd18, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[19] = '{V_MR,   32'd2, 32'd19, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[20] = '{V_WB,   32'd2, 32'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[21] = '{V_IDLE, 32'd3, 32'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      @(posedge clk);
      do_reset();

      for (int i = 0; i < 22; i++) begin
         chk($sformatf("vec%0d outputs", i), 32'(outv), 32'(tbl[i].exp));
         chk($sformatf("vec%0d retired", i), retired, tbl[i].ret);
         chk($sformatf("vec%0d cycles", i), cycles, tbl[i].cyc);
         run = tbl[i].run; mem_read = tbl[i].rd; mem_write = tbl[i].wr;
         reg_write = tbl[i].rw; mem_ack = tbl[i].ack; halt_req = tbl[i].hlt;
         @(posedge clk);
         #1;
      end
      m_ret = 32'd3; m_cyc = 32'd22; m_in_wb = 1'b0; m_stop = 1'b0;

      // ack arriving in the same cycle the timeout would expire
      run = 1'b1;
      instr(1'b1, 1'b0, 1'b1, TMO, f);
      chk("ack beats timeout", 32'(f), 32'd0);

      for (int i = 0; i < 40; i++) begin
         gap  = $urandom_range(0, 2);
         mode = $urandom_range(0, 3);
         dly  = $urandom_range(0, TMO);
         if (gap != 0) begin
            run = 1'b0;
            for (int g = 0; g < int'(gap); g++) begin
               tick(V_IDLE, "idle gap");
               halt_req  = 1'($urandom_range(0, 1));
               mem_ack   = 1'($urandom_range(0, 1));
               mem_read  = 1'($urandom_range(0, 1));
               mem_write = 1'($urandom_range(0, 1));
            end
         end
         run = 1'b1;
         instr(mode[0], mode[1], 1'($urandom_range(0, 1)), dly, f);
      end

      // halt requested in WRITEBACK: instruction retires, then no more fetches
      run = 1'b1;
      halt_req = 1'b1;
      tick(V_HALT, "halt entry");
      halt_req = 1'b0;
      for (int i = 0; i < 4; i++) tick(V_HALT, "halt hold");

      // store never acknowledged
      do_reset();
      run = 1'b1;
      instr(1'b0, 1'b1, 1'b1, 100, f);
      chk("timeout reached", 32'(f), 32'd1);
      run = 1'b1; mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) tick(V_FAULT, "fault hold");
      mem_ack = 1'b0;

      // reset in the middle of MEM_WAIT, then a clean instruction
      do_reset();
      run = 1'b1; mem_read = 1'b1; reg_write = 1'b1; mem_ack = 1'b0;
      tick(V_F, "abort fetch");
      tick(V_D, "abort decode");
      tick(V_E, "abort execute");
      tick(V_MR, "abort memory");
      tick(V_W, "abort wait1");
      tick(V_W, "abort wait2");
      do_reset();
      run = 1'b1;
      instr(1'b0, 1'b0, 1'b1, 0, f);
      run = 1'b0;
      tick(V_IDLE, "after abort idle");

      // instance with MAX_INSTR=20
      @(posedge clk);
      #1 reset1 = 1'b1; run1 = 1'b1;
      n_pu = 0; n_f = 0; prev_pu = 1'b0; halt_after_pu = 1'b0;
      for (int k = 0; k < 300 && !halted1; k++) begin
         @(posedge clk);
         #1;
         if (pc_update1) n_pu++;
         if (fetch_en1) n_f++;
         if (halted1) halt_after_pu = prev_pu && (n_pu == 20);
         prev_pu = pc_update1;
      end
      chk("limit halted", 32'(halted1), 32'd1);
      chk("limit halt timing", 32'(halt_after_pu), 32'd1);
      chk("limit pc_update count", n_pu, 32'd20);
      chk("limit retired", retired1, 32'd20);
      chk("limit cycles", cycles1, 32'd101);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (fetch_en1) n_f++;
      end
      chk("limit fetch count", n_f, 32'd20);
      chk("limit cycles frozen", cycles1, 32'd101);
      chk("limit fault clear", 32'(fault1), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
